// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: 16x-oversampling UART receiver. The frame is 8N1, or 8E1 when UART_RX_PARITY_EN is defined.
// Received bytes are buffered in a small FIFO that drains through a valid/ready stream.
module uart_rx_fifo #(
    parameter int CLK_HZ     = 50_000_000,
    parameter int BAUD       = 115200,
    parameter int FIFO_DEPTH = 8
) (
    input  logic       CLOCK_50,
    input  logic       RESET_N,
    input  logic       UART_RXD,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    input  logic       rx_ready,
    output logic       frame_err,
    output logic       overrun,
    output logic       par_err
);
    localparam int DIV = (CLK_HZ + BAUD * 8) / (BAUD * 16);
    localparam int TW  = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int AW  = $clog2(FIFO_DEPTH);
    localparam logic [TW-1:0] TICK_LAST = TW'(DIV - 1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP
`ifdef UART_RX_PARITY_EN
        , PARITY
`endif
    } state_t;

    state_t        state_q, state_d;
    logic          sync1_q, sync2_q, rxdPrev_q;
    logic          rxdS, startEdge, tick, sampleNow;
    logic [TW-1:0] tickCnt_q, tickCnt_d;
    logic [3:0]    sampleCnt_q, sampleCnt_d;
    logic [2:0]    bitIdx_q, bitIdx_d;
    logic [7:0]    shift_q, shift_d;
    logic          frameErr_q, frameErr_d;
    logic          overrun_q, overrun_d;
    logic          byteDone;
    logic          fifoFull, fifoEmpty, fifoWrite, fifoPop;
    logic [AW:0]   wrPtr_q, rdPtr_q;
    logic [7:0]    mem_q [FIFO_DEPTH];
`ifdef UART_RX_PARITY_EN
    logic          parBad_q, parBad_d;
    logic          parErr_q, parErr_d;
`endif

    always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
        if (!RESET_N) begin
            sync1_q   <= 1'b1;
            sync2_q   <= 1'b1;
            rxdPrev_q <= 1'b1;
        end else begin
            sync1_q   <= UART_RXD;
            sync2_q   <= sync1_q;
            rxdPrev_q <= sync2_q;
        end
    end

    assign rxdS      = sync2_q;
    assign startEdge = rxdPrev_q & ~rxdS;
    assign tick      = (state_q != IDLE) && (tickCnt_q == TICK_LAST);
    assign sampleNow = tick && (sampleCnt_q == 4'd7);

    always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
        if (!RESET_N) begin
            state_q     <= IDLE;
            tickCnt_q   <= '0;
            sampleCnt_q <= '0;
            bitIdx_q    <= '0;
            shift_q     <= '0;
            frameErr_q  <= 1'b0;
            overrun_q   <= 1'b0;
`ifdef UART_RX_PARITY_EN
            parBad_q    <= 1'b0;
            parErr_q    <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            tickCnt_q   <= tickCnt_d;
            sampleCnt_q <= sampleCnt_d;
            bitIdx_q    <= bitIdx_d;
            shift_q     <= shift_d;
            frameErr_q  <= frameErr_d;
            overrun_q   <= overrun_d;
`ifdef UART_RX_PARITY_EN
            parBad_q    <= parBad_d;
            parErr_q    <= parErr_d;
`endif
        end
    end

    // Leaving STOP at its mid-bit sample lets a new start edge be caught from the half-bit point on.
    always_comb begin
        state_d     = state_q;
        tickCnt_d   = tickCnt_q;
        sampleCnt_d = sampleCnt_q;
        bitIdx_d    = bitIdx_q;
        shift_d     = shift_q;
        frameErr_d  = 1'b0;
        byteDone    = 1'b0;
`ifdef UART_RX_PARITY_EN
        parBad_d    = parBad_q;
        parErr_d    = 1'b0;
`endif
        if (state_q != IDLE) begin
            tickCnt_d = tick ? '0 : tickCnt_q + TW'(1);
            if (tick) begin
                sampleCnt_d = sampleCnt_q + 4'd1;
            end
        end
        case (state_q)
            IDLE: begin
                if (startEdge) begin
                    state_d     = START;
                    tickCnt_d   = '0;
                    sampleCnt_d = '0;
                end
            end
            START: begin
                if (sampleNow) begin
                    if (!rxdS) begin
                        state_d  = DATA;
                        bitIdx_d = '0;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            DATA: begin
                if (sampleNow) begin
                    shift_d  = {rxdS, shift_q[7:1]};
                    bitIdx_d = bitIdx_q + 3'd1;
                    if (bitIdx_q == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                        state_d = PARITY;
`else
                        state_d = STOP;
`endif
                    end
                end
            end
`ifdef UART_RX_PARITY_EN
            PARITY: begin
                if (sampleNow) begin
                    parBad_d = (rxdS != ^shift_q);
                    state_d  = STOP;
                end
            end
`endif
            STOP: begin
                if (sampleNow) begin
                    state_d = IDLE;
                    if (!rxdS) begin
                        frameErr_d = 1'b1;
                    end
`ifdef UART_RX_PARITY_EN
                    else if (parBad_q) begin
                        parErr_d = 1'b1;
                    end
`endif
                    else begin
                        byteDone = 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // A pop in the same cycle frees the slot, so a push onto a full FIFO is only lost without one.
    assign fifoEmpty = (wrPtr_q == rdPtr_q);
    assign fifoFull  = (wrPtr_q[AW] != rdPtr_q[AW]) && (wrPtr_q[AW-1:0] == rdPtr_q[AW-1:0]);
    assign fifoPop   = ~fifoEmpty & rx_ready;
    assign fifoWrite = byteDone & (~fifoFull | fifoPop);
    assign overrun_d = byteDone & fifoFull & ~fifoPop;

    always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
        if (!RESET_N) begin
            wrPtr_q <= '0;
            rdPtr_q <= '0;
        end else begin
            if (fifoWrite) begin
                wrPtr_q <= wrPtr_q + (AW+1)'(1);
            end
            if (fifoPop) begin
                rdPtr_q <= rdPtr_q + (AW+1)'(1);
            end
        end
    end

    always_ff @(posedge CLOCK_50) begin
        if (fifoWrite) begin
            mem_q[wrPtr_q[AW-1:0]] <= shift_q;
        end
    end

    assign rx_valid  = ~fifoEmpty;
    assign rx_data   = fifoEmpty ? 8'h00 : mem_q[rdPtr_q[AW-1:0]];
    assign frame_err = frameErr_q;
    assign overrun   = overrun_q;
`ifdef UART_RX_PARITY_EN
    assign par_err   = parErr_q;
`else
    assign par_err   = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx_fifo.sv
// tb_uart_rx_fifo: drives jittered serial frames into uart_rx_fifo and compares bytes and error pulses
// against a queue-based model of the receiver. Also covers the UART_RX_PARITY_EN build.
module tb_uart_rx_fifo;
    // The DUT runs at a higher baud so the whole run stays short; every timing below scales with BIT.
    localparam int CLK_HZ     = 50_000_000;
    localparam int BAUD       = 460_800;
    localparam int FIFO_DEPTH = 8;
    localparam int DIV        = (CLK_HZ + BAUD * 8) / (BAUD * 16);
    localparam int BIT        = 16 * DIV;
    localparam int JIT        = BIT / 50;
`ifdef UART_RX_PARITY_EN
    localparam int PRE_STOP_BITS = 10;
`else
    localparam int PRE_STOP_BITS = 9;
`endif
    // The line passes two synchroniser flops and then an edge register before the frame timer starts.
    localparam int SYNC_LAT = 3;
    localparam int STOP_T   = PRE_STOP_BITS * BIT + BIT / 2 + SYNC_LAT;

    logic       CLOCK_50 = 1'b0;
    logic       RESET_N  = 1'b0;
    logic       UART_RXD = 1'b1;
    logic       rx_ready = 1'b0;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       frame_err;
    logic       overrun;
    logic       par_err;

    int checks = 0;
    int errors = 0;
    int frameErrCnt = 0, overrunCnt = 0, parErrCnt = 0;
    int expFrameErr = 0, expOverrun = 0, expParErr = 0;
    logic [7:0] expQ[$];
`ifdef UART_RX_PARITY_EN
    bit   parityForce = 1'b0;
    logic parityOverride = 1'b0;
`endif

    uart_rx_fifo #(
        .CLK_HZ    (CLK_HZ),
        .BAUD      (BAUD),
        .FIFO_DEPTH(FIFO_DEPTH)
    ) dut (
        .CLOCK_50 (CLOCK_50),
        .RESET_N  (RESET_N),
        .UART_RXD (UART_RXD),
        .rx_data  (rx_data),
        .rx_valid (rx_valid),
        .rx_ready (rx_ready),
        .frame_err(frame_err),
        .overrun  (overrun),
        .par_err  (par_err)
    );

    always #10 CLOCK_50 = ~CLOCK_50;

    always @(negedge CLOCK_50) begin
        if (frame_err === 1'b1) frameErrCnt++;
        if (overrun === 1'b1) overrunCnt++;
        if (par_err === 1'b1) parErrCnt++;
    end

    initial begin
        repeat (100000) @(posedge CLOCK_50);
        $display("[TB] FAIL watchdog observed=still_running expected=finished");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
        end
    endtask

    task automatic idleLine(input int n);
        UART_RXD = 1'b1;
        repeat (n) @(negedge CLOCK_50);
    endtask

    // Called on a negedge; leaves the line at the stop-bit level when the stop bit ends.
    task automatic applyStimulus(input logic [7:0] data, input logic stopBit, input bit jitter);
        logic frameBits[$];
        int   len;
        frameBits.push_back(1'b0);
        for (int i = 0; i < 8; i++) frameBits.push_back(data[i]);
`ifdef UART_RX_PARITY_EN
        frameBits.push_back(parityForce ? parityOverride : ^data);
`endif
        frameBits.push_back(stopBit);
        foreach (frameBits[i]) begin
            UART_RXD = frameBits[i];
            len = jitter ? BIT - JIT + int'($urandom_range(2 * JIT)) : BIT;
            repeat (len) @(negedge CLOCK_50);
        end
    endtask

    task automatic modelFrame(input logic [7:0] data, input logic stopBit);
`ifdef UART_RX_PARITY_EN
        logic sentParity;
        sentParity = parityForce ? parityOverride : ^data;
`endif
        if (stopBit !== 1'b1) expFrameErr++;
`ifdef UART_RX_PARITY_EN
        else if (sentParity != ^data) expParErr++;
`endif
        else if (expQ.size() >= FIFO_DEPTH) expOverrun++;
        else expQ.push_back(data);
    endtask

    task automatic checkCounters(input string tag);
        checkOutput({tag, "_frame_err"}, frameErrCnt, expFrameErr);
        checkOutput({tag, "_overrun"}, overrunCnt, expOverrun);
        checkOutput({tag, "_par_err"}, parErrCnt, expParErr);
    endtask

    task automatic drainAndCheck(input string tag);
        int         guard = 0;
        logic [7:0] expByte;
        @(negedge CLOCK_50);
        rx_ready = 1'b1;
        while (expQ.size() > 0 && guard < 4 * FIFO_DEPTH) begin
            if (rx_valid === 1'b1) begin
                expByte = expQ.pop_front();
                checkOutput({tag, "_data"}, rx_data, expByte);
            end
            guard++;
            @(negedge CLOCK_50);
        end
        checkOutput({tag, "_left"}, expQ.size(), 0);
        checkOutput({tag, "_empty"}, rx_valid, 1'b0);
        rx_ready = 1'b0;
        expQ.delete();
    endtask

    initial begin
        int         riseT;
        logic [7:0] b;
        logic [7:0] expByte;

        $display("[TB] start: DIV=%0d bit=%0d clocks", DIV, BIT);
        repeat (5) @(negedge CLOCK_50);
        checkOutput("rst_valid", rx_valid, 1'b0);
        checkOutput("rst_data", rx_data, 8'h00);
        checkOutput("rst_frame_err", frame_err, 1'b0);
        checkOutput("rst_overrun", overrun, 1'b0);
        checkOutput("rst_par_err", par_err, 1'b0);
        RESET_N = 1'b1;
        idleLine(20);

        // Reset lands in data bit 3 and is held until the line is idle again.
        fork
            applyStimulus(8'h5A, 1'b1, 1'b1);
            begin
                repeat (4 * BIT + BIT / 2) @(negedge CLOCK_50);
                RESET_N = 1'b0;
            end
        join
        idleLine(20);
        checkOutput("midrst_valid", rx_valid, 1'b0);
        RESET_N = 1'b1;
        idleLine(2 * BIT);
        checkOutput("midrst_idle_valid", rx_valid, 1'b0);
        checkOutput("midrst_idle_data", rx_data, 8'h00);
        checkCounters("midrst");

        $display("[TB] single byte");
        riseT = -1;
        fork
            applyStimulus(8'hA5, 1'b1, 1'b0);
            begin
                for (int t = 1; t <= (PRE_STOP_BITS + 1) * BIT && riseT < 0; t++) begin
                    @(negedge CLOCK_50);
                    if (rx_valid === 1'b1) riseT = t;
                end
            end
        join
        modelFrame(8'hA5, 1'b1);
        checkOutput("single_latency_ok", (riseT >= STOP_T - 2) && (riseT <= STOP_T + 2), 1'b1);
        checkOutput("single_data", rx_data, expQ[0]);
        idleLine(5);
        rx_ready = 1'b1;
        @(negedge CLOCK_50);
        rx_ready = 1'b0;
        void'(expQ.pop_front());
        checkOutput("single_popped", rx_valid, 1'b0);
        idleLine(20);

        $display("[TB] glitch");
        UART_RXD = 1'b0;
        repeat (BIT / 4) @(negedge CLOCK_50);
        idleLine(BIT / 2 + SYNC_LAT + 2 - BIT / 4);
        checkOutput("glitch_valid", rx_valid, 1'b0);
        checkCounters("glitch");
        b = 8'($urandom);
        applyStimulus(b, 1'b1, 1'b1);
        modelFrame(b, 1'b1);
        idleLine(20);
        checkCounters("glitch_next");
        drainAndCheck("glitch_next");

        $display("[TB] framing and break");
        applyStimulus(8'h3C, 1'b0, 1'b1);
        modelFrame(8'h3C, 1'b0);
        repeat (3 * BIT) @(negedge CLOCK_50);
        idleLine(BIT);
        checkOutput("frame_valid", rx_valid, 1'b0);
        checkCounters("frame");
        b = 8'($urandom);
        applyStimulus(b, 1'b1, 1'b1);
        modelFrame(b, 1'b1);
        idleLine(20);
        drainAndCheck("after_break");

        $display("[TB] random burst");
        for (int i = 0; i < 5; i++) begin
            b = 8'($urandom);
            applyStimulus(b, 1'b1, 1'b1);
            modelFrame(b, 1'b1);
            idleLine(2 + int'($urandom_range(BIT / 4)));
        end
        checkCounters("burst");
        drainAndCheck("burst");

        $display("[TB] overrun");
        for (int i = 0; i < 9; i++) begin
            applyStimulus(8'(i), 1'b1, 1'b1);
            modelFrame(8'(i), 1'b1);
            idleLine(10);
        end
        checkCounters("ovr1");
        drainAndCheck("ovr1");

        $display("[TB] pop on the ninth stop sample");
        for (int i = 0; i < 8; i++) begin
            applyStimulus(8'(i), 1'b1, 1'b1);
            modelFrame(8'(i), 1'b1);
            idleLine(10);
        end
        fork
            applyStimulus(8'h08, 1'b1, 1'b0);
            begin
                repeat (STOP_T - 1) @(negedge CLOCK_50);
                checkOutput("ovr2_full_valid", rx_valid, 1'b1);
                expByte = expQ.pop_front();
                checkOutput("ovr2_pop0", rx_data, expByte);
                rx_ready = 1'b1;
                @(negedge CLOCK_50);
                expByte = expQ.pop_front();
                checkOutput("ovr2_pop1", rx_data, expByte);
                @(negedge CLOCK_50);
                rx_ready = 1'b0;
            end
        join
        modelFrame(8'h08, 1'b1);
        idleLine(20);
        checkCounters("ovr2");
        checkOutput("ovr2_last_queued", expQ[$], 8'h08);
        drainAndCheck("ovr2");

`ifdef UART_RX_PARITY_EN
        $display("[TB] parity");
        parityForce = 1'b1;
        parityOverride = 1'b1;
        applyStimulus(8'h07, 1'b1, 1'b1);
        modelFrame(8'h07, 1'b1);
        idleLine(20);
        parityOverride = 1'b0;
        applyStimulus(8'h07, 1'b1, 1'b1);
        modelFrame(8'h07, 1'b1);
        idleLine(20);
        parityForce = 1'b0;
        checkCounters("parity");
        drainAndCheck("parity");
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
